apb_req_arbiter: RTL and testbench
==================================

Name: apb_req_arbiter

Overview:
- Shares the single APB master port between two byte-wide requesters: m0 (host command path) and m1 (I2C-slave bridge).
- Selects one requester round-robin and sequences a full APB3 SETUP/ACCESS transfer with pready wait-states.
- Returns read data and completion/error status to the granted requester.
- Sits between the requesters and the APB slave fabric, replacing direct pulse-driven APB sequencing.

Parameters:
- TIMEOUT, 16, number of ACCESS cycles with pready low before the transfer is aborted (legal range 2..255).
- CNT_W, 8, width of the wait-state counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- pclk  input  1  APB clock
- prst_n  input  1  reset; asynchronous, active-low
- m0_req  input  1  requester 0 transfer request (level, held until m0_done)
- m0_write  input  1  1 = write, 0 = read
- m0_addr  input  8  byte address
- m0_wdata  input  8  write data
- m0_rdata  output  8  read data, valid while m0_done=1
- m0_done  output  1  one-cycle completion pulse
- m0_err  output  1  error qualifier, valid while m0_done=1
- m1_req, m1_write, m1_addr, m1_wdata, m1_rdata, m1_done, m1_err  same as m0_* for requester 1
- psel  output  1  APB select
- penable  output  1  APB enable
- pwrite  output  1  APB direction
- paddr  output  32  APB address, {24'h0, addr}
- pwdata  output  32  APB write data, {24'h0, wdata}
- prdata  input  32  APB read data; only [7:0] is used
- pready  input  1  APB ready
- pslverr  input  1  APB slave error
- busy  output  1  high in SETUP/ACCESS

Behaviour:
- Reset (async, immediate, including mid-transfer):
  - state=IDLE; psel, penable, pwrite, busy, mN_done, mN_err = 0.
  - paddr, pwdata, mN_rdata = 0.
  - last_gnt=1, so m0 wins the first contention.
  - Wait counter = 0.
- All outputs are registered; there are no combinational input-to-output paths.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - If any eligible req is high at edge N: latch the winner's write/addr/wdata into pwrite/paddr/pwdata; set psel=1, busy=1; go to SETUP; set last_gnt=winner.
  - Otherwise psel, penable, busy = 0.
- Eligibility: a requester whose mN_done is high in the current cycle is not eligible. This forces a minimum of 2 cycles between its own transfers and lets it drop req.
- Arbitration:
  - Only one eligible req high: it wins.
  - Both eligible: the requester != last_gnt wins (strict alternation under continuous contention).
- SETUP: penable=1 at the next edge; go to ACCESS; wait counter cleared.
- ACCESS with pready=1 at an edge:
  - psel=0, penable=0, busy=0; state=IDLE.
  - Granted mN_done=1 for exactly one cycle; mN_err=pslverr.
  - On a read, mN_rdata=prdata[7:0]. On a write, mN_rdata holds its previous value.
- ACCESS with pready=0: counter increments.
- Timeout: if the counter equals TIMEOUT-1 and pready=0 at the edge, abort as a normal completion with mN_err=1 and mN_rdata=8'h00 (reads only).
- Nominal latency: req sampled at edge N → psel from N+1 → penable from N+2 → done from N+3 when pready=1, for 3 cycles minimum.
- paddr, pwdata and pwrite are stable from SETUP through the final ACCESS cycle.
- They hold their values in IDLE after a transfer and only change on a new grant.
- req dropped mid-transfer is ignored; the transfer completes and done still pulses.
- The non-granted requester's done/err/rdata are untouched.
- pready/pslverr are ignored outside ACCESS.

Test Plan:
- m0 write, addr 8'h12, wdata 8'hA5, pready tied 1 → SETUP: psel=1, penable=0, pwrite=1, paddr=32'h12, pwdata=32'hA5; next cycle penable=1; next cycle m0_done=1, m0_err=0, psel=0.
- m1 read, addr 8'h40, prdata=32'hDEAD_BE3C, pready low 3 ACCESS cycles then high → m1_done one cycle after pready, m1_rdata=8'h3C, ACCESS lasts 4 cycles.
- m0 and m1 request simultaneously from reset, both held continuous → grant order m0, m1, m0, m1; each done pulse reaches only its own requester.
- pready held 0, TIMEOUT=16 → exactly 16 ACCESS cycles, then done=1, err=1, rdata=8'h00; next request proceeds normally.
- Write completes with pslverr=1 at pready → m0_err=1 for one cycle with done.
- prst_n asserted during ACCESS → psel, penable, busy, done drop without waiting for a clock edge; after release the FSM is in IDLE and m0 wins the next contention.

Source files
------------

// File: rtl/apb_req_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : apb_req_arbiter_if
// Description : APB3 bus bundle between the requester arbiter and the slave
//               fabric.
//               master modport : psel/penable/pwrite/paddr/pwdata out,
//                                prdata/pready/pslverr in
//               slave  modport : the mirror image
// Revision    : 1.0 - initial release
// ============================================================================
interface apb_req_arbiter_if;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [31:0] paddr;
   logic [31:0] pwdata;
   logic [31:0] prdata;
   logic        pready;
   logic        pslverr;

   modport master (
      output psel, penable, pwrite, paddr, pwdata,
      input  prdata, pready, pslverr
   );

   modport slave (
      input  psel, penable, pwrite, paddr, pwdata,
      output prdata, pready, pslverr
   );
endinterface
`default_nettype wire

// File: rtl/apb_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : apb_req_arbiter
// Description : Round-robin arbiter sharing one APB3 master port between two
//               byte-wide requesters (m0 host path, m1 I2C bridge). It runs a
//               full SETUP/ACCESS transfer with wait states and a timeout, and
//               returns rdata/done/err to the granted requester.
// Ports       : pclk, prst_n (async, active-low)
//               m0_* / m1_* : req/write/addr/wdata in, rdata/done/err out
//               apb         : APB3 master modport (bus towards the slaves)
//               busy        : high while in SETUP or ACCESS
// Revision    : 1.0 - initial release
// ============================================================================
module apb_req_arbiter #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 8
) (
   input  wire                logic pclk,
   input  wire                logic prst_n,
   input  wire                logic m0_req,
   input  wire                logic m0_write,
   input  wire                logic [7:0] m0_addr,
   input  wire                logic [7:0] m0_wdata,
   output logic [7:0]         m0_rdata,
   output logic               m0_done,
   output logic               m0_err,
   input  wire                logic m1_req,
   input  wire                logic m1_write,
   input  wire                logic [7:0] m1_addr,
   input  wire                logic [7:0] m1_wdata,
   output logic [7:0]         m1_rdata,
   output logic               m1_done,
   output logic               m1_err,
   apb_req_arbiter_if.master  apb,
   output logic               busy
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SETUP  = 2'd1;
   localparam logic [1:0] S_ACCESS = 2'd2;

   localparam logic [CNT_W-1:0] c_TO_LAST = CNT_W'(TIMEOUT - 1);

   logic [1:0]       r_state;
   logic             r_psel;
   logic             r_penable;
   logic             r_pwrite;
   logic [7:0]       r_paddr;
   logic [7:0]       r_pwdata;
   logic             r_busy;
   logic             r_last_gnt;   // also the grant of the transfer in flight
   logic [CNT_W-1:0] r_cnt;
   logic             r_done0, r_done1;
   logic             r_err0,  r_err1;
   logic [7:0]       r_rdata0, r_rdata1;

   // A requester whose done is still high cannot win again this cycle; this
   // gives it time to drop req and enforces alternation under contention.
   logic w_elig0, w_elig1, w_win;
   logic w_tout, w_finish, w_err;
   logic [7:0] w_rd;

   assign w_elig0 = m0_req & ~r_done0;
   assign w_elig1 = m1_req & ~r_done1;
   // Winner index: m1 if only m1 eligible, or both eligible and m0 went last.
   assign w_win   = w_elig1 & (~w_elig0 | ~r_last_gnt);

   assign w_tout   = ~apb.pready & (r_cnt == c_TO_LAST);
   assign w_finish = apb.pready | w_tout;
   assign w_err    = w_tout | apb.pslverr;
   assign w_rd     = w_tout ? 8'h00 : apb.prdata[7:0];

   always_ff @(posedge pclk or negedge prst_n) begin
      if (!prst_n) begin
         r_state    <= S_IDLE;
         r_psel     <= 1'b0;
         r_penable  <= 1'b0;
         r_pwrite   <= 1'b0;
         r_paddr    <= 8'h00;
         r_pwdata   <= 8'h00;
         r_busy     <= 1'b0;
         r_last_gnt <= 1'b1;
         r_cnt      <= '0;
         r_done0    <= 1'b0;
         r_done1    <= 1'b0;
         r_err0     <= 1'b0;
         r_err1     <= 1'b0;
         r_rdata0   <= 8'h00;
         r_rdata1   <= 8'h00;
      end else begin
         r_done0 <= 1'b0;
         r_done1 <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_penable <= 1'b0;
               if (w_elig0 | w_elig1) begin
                  r_pwrite   <= w_win ? m1_write : m0_write;
                  r_paddr    <= w_win ? m1_addr  : m0_addr;
                  r_pwdata   <= w_win ? m1_wdata : m0_wdata;
                  r_psel     <= 1'b1;
                  r_busy     <= 1'b1;
                  r_last_gnt <= w_win;
                  r_state    <= S_SETUP;
               end else begin
                  r_psel <= 1'b0;
                  r_busy <= 1'b0;
               end
            end
            S_SETUP: begin
               r_penable <= 1'b1;
               r_cnt     <= '0;
               r_state   <= S_ACCESS;
            end
            S_ACCESS: begin
               if (w_finish) begin
                  r_psel    <= 1'b0;
                  r_penable <= 1'b0;
                  r_busy    <= 1'b0;
                  r_state   <= S_IDLE;
                  if (r_last_gnt) begin
                     r_done1 <= 1'b1;
                     r_err1  <= w_err;
                     if (!r_pwrite) r_rdata1 <= w_rd;
                  end else begin
                     r_done0 <= 1'b1;
                     r_err0  <= w_err;
                     if (!r_pwrite) r_rdata0 <= w_rd;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
               r_psel    <= 1'b0;
               r_penable <= 1'b0;
               r_busy    <= 1'b0;
               r_state   <= S_IDLE;
            end
         endcase
      end
   end

   assign apb.psel    = r_psel;
   assign apb.penable = r_penable;
   assign apb.pwrite  = r_pwrite;
   assign apb.paddr   = {24'h0, r_paddr};
   assign apb.pwdata  = {24'h0, r_pwdata};
   assign busy        = r_busy;
   assign m0_done     = r_done0;
   assign m0_err      = r_err0;
   assign m0_rdata    = r_rdata0;
   assign m1_done     = r_done1;
   assign m1_err      = r_err1;
   assign m1_rdata    = r_rdata1;

   // Only the low byte of read data is meaningful to byte-wide requesters.
   logic w_unused;
   assign w_unused = &{1'b0, apb.prdata[31:8]};

endmodule
`default_nettype wire

// File: tb/tb_apb_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_req_arbiter
// Description : Directed self-checking bench for apb_req_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_req_arbiter;

   logic       pclk;
   logic       prst_n;
   logic       m0_req, m0_write, m1_req, m1_write;
   logic [7:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic [7:0] m0_rdata, m1_rdata;
   logic       m0_done, m0_err, m1_done, m1_err;
   logic       busy;

   int total;
   int bad;

   apb_req_arbiter_if bus ();

   apb_req_arbiter #(.TIMEOUT(16), .CNT_W(8)) dut (
      .pclk     (pclk),
      .prst_n   (prst_n),
      .m0_req   (m0_req),
      .m0_write (m0_write),
      .m0_addr  (m0_addr),
      .m0_wdata (m0_wdata),
      .m0_rdata (m0_rdata),
      .m0_done  (m0_done),
      .m0_err   (m0_err),
      .m1_req   (m1_req),
      .m1_write (m1_write),
      .m1_addr  (m1_addr),
      .m1_wdata (m1_wdata),
      .m1_rdata (m1_rdata),
      .m1_done  (m1_done),
      .m1_err   (m1_err),
      .apb      (bus.master),
      .busy     (busy)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one edge and settle 1 ns after it; inputs change here too.
   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      prst_n = 1'b0;
      m0_req = 0; m0_write = 0; m0_addr = 0; m0_wdata = 0;
      m1_req = 0; m1_write = 0; m1_addr = 0; m1_wdata = 0;
      bus.prdata = 32'h0; bus.pready = 1'b1; bus.pslverr = 1'b0;
      tick(); tick();
      prst_n = 1'b1;
      tick();

      // Reset state
      chk("rst_psel",    {31'h0, bus.psel},    32'h0);
      chk("rst_penable", {31'h0, bus.penable}, 32'h0);
      chk("rst_busy",    {31'h0, busy},        32'h0);
      chk("rst_paddr",   bus.paddr,            32'h0);
      chk("rst_pwdata",  bus.pwdata,           32'h0);
      chk("rst_done",    {30'h0, m0_done, m1_done}, 32'h0);
      chk("rst_rdata",   {16'h0, m0_rdata, m1_rdata}, 32'h0);

      // m0 write 0x12 <= 0xA5, zero wait states
      m0_req = 1; m0_write = 1; m0_addr = 8'h12; m0_wdata = 8'hA5;
      tick();
      chk("w_setup_psel",    {31'h0, bus.psel},    32'h1);
      chk("w_setup_penable", {31'h0, bus.penable}, 32'h0);
      chk("w_setup_pwrite",  {31'h0, bus.pwrite},  32'h1);
      chk("w_setup_paddr",   bus.paddr,            32'h12);
      chk("w_setup_pwdata",  bus.pwdata,           32'hA5);
      chk("w_setup_busy",    {31'h0, busy},        32'h1);
      tick();
      chk("w_access_penable", {31'h0, bus.penable}, 32'h1);
      chk("w_access_paddr",   bus.paddr,            32'h12);
      tick();
      chk("w_done",      {31'h0, m0_done},  32'h1);
      chk("w_err",       {31'h0, m0_err},   32'h0);
      chk("w_done_psel", {31'h0, bus.psel}, 32'h0);
      chk("w_m1_quiet",  {31'h0, m1_done},  32'h0);
      m0_req = 0;
      tick();
      chk("w_done_pulse", {31'h0, m0_done}, 32'h0);
      chk("w_hold_paddr", bus.paddr,        32'h12);

      // m1 read 0x40 with three wait states
      m1_req = 1; m1_write = 0; m1_addr = 8'h40;
      bus.prdata = 32'hDEAD_BE3C; bus.pready = 0;
      tick();
      chk("r_setup_paddr",  bus.paddr,           32'h40);
      chk("r_setup_pwrite", {31'h0, bus.pwrite}, 32'h0);
      tick(); tick(); tick(); tick();
      chk("r_wait_done",    {31'h0, m1_done},     32'h0);
      chk("r_wait_penable", {31'h0, bus.penable}, 32'h1);
      bus.pready = 1;
      tick();
      chk("r_done",    {31'h0, m1_done}, 32'h1);
      chk("r_rdata",   {24'h0, m1_rdata}, 32'h3C);
      chk("r_err",     {31'h0, m1_err},  32'h0);
      chk("r_m0_quiet", {23'h0, m0_done, m0_rdata}, 32'h0);
      m1_req = 0;
      tick();
      chk("r_done_pulse", {31'h0, m1_done},  32'h0);
      chk("r_rdata_hold", {24'h0, m1_rdata}, 32'h3C);

      // Continuous contention: strict alternation m0, m1, m0, m1
      m0_req = 1; m0_write = 1; m0_addr = 8'h01; m0_wdata = 8'h11;
      m1_req = 1; m1_write = 1; m1_addr = 8'h02; m1_wdata = 8'h22;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("rr_paddr",  bus.paddr,  (k % 2 == 0) ? 32'h01 : 32'h02);
         chk("rr_pwdata", bus.pwdata, (k % 2 == 0) ? 32'h11 : 32'h22);
         tick();
         tick();
         chk("rr_done", {30'h0, m1_done, m0_done}, (k % 2 == 0) ? 32'h1 : 32'h2);
      end
      m0_req = 0; m1_req = 0;
      tick();

      // m1 read timeout: pready stuck low for 16 ACCESS cycles
      m1_req = 1; m1_write = 0; m1_addr = 8'h77; bus.pready = 0;
      tick();
      chk("to_paddr", bus.paddr, 32'h77);
      tick();
      for (int i = 0; i < 15; i++) tick();
      chk("to_not_yet", {31'h0, m1_done},  32'h0);
      chk("to_busy",    {31'h0, busy},     32'h1);
      tick();
      chk("to_done",  {31'h0, m1_done},  32'h1);
      chk("to_err",   {31'h0, m1_err},   32'h1);
      chk("to_rdata", {24'h0, m1_rdata}, 32'h00);
      chk("to_psel",  {31'h0, bus.psel}, 32'h0);
      m1_req = 0; bus.pready = 1;
      tick();

      // Recovery after timeout
      m1_req = 1; m1_addr = 8'h78; bus.prdata = 32'h0000_0081;
      tick(); tick(); tick();
      chk("rec_done",  {31'h0, m1_done},  32'h1);
      chk("rec_err",   {31'h0, m1_err},   32'h0);
      chk("rec_rdata", {24'h0, m1_rdata}, 32'h81);
      m1_req = 0;
      tick();

      // Slave error on a write
      m0_req = 1; m0_write = 1; m0_addr = 8'h20; m0_wdata = 8'h5A; bus.pslverr = 1;
      tick(); tick(); tick();
      chk("se_done", {31'h0, m0_done}, 32'h1);
      chk("se_err",  {31'h0, m0_err},  32'h1);
      m0_req = 0; bus.pslverr = 0;
      tick();
      chk("se_done_pulse", {31'h0, m0_done}, 32'h0);

      // Asynchronous reset in the middle of ACCESS
      m0_req = 1; m0_addr = 8'h33; bus.pready = 0;
      tick(); tick(); tick();
      chk("ar_pre_penable", {31'h0, bus.penable}, 32'h1);
      #1 prst_n = 0;
      #2;
      chk("ar_psel",    {31'h0, bus.psel},    32'h0);
      chk("ar_penable", {31'h0, bus.penable}, 32'h0);
      chk("ar_busy",    {31'h0, busy},        32'h0);
      chk("ar_rdata",   {24'h0, m1_rdata},    32'h0);
      m0_req = 0;
      tick();
      prst_n = 1; bus.pready = 1;
      m0_req = 1; m0_write = 1; m0_addr = 8'h33;
      m1_req = 1; m1_write = 1; m1_addr = 8'h44;
      tick();
      chk("ar_first_win", bus.paddr, 32'h33);
      tick(); tick();
      chk("ar_first_done", {30'h0, m1_done, m0_done}, 32'h1);
      m0_req = 0; m1_req = 0;
      tick(); tick(); tick(); tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
